csadd_pipe: RTL

- Parametrised, pipelined carry-select adder/subtractor.
- Successor to the team's fixed 32-bit combinational carry-select adder.
- Operands are split into SEG_W-bit segments. Each pipeline stage resolves one segment by carry-select and registers the carry into the next stage.
- Valid/ready handshakes on both sides. Full throughput of one operation per cycle. Used as the ALU add path in the lab datapath.

---
 rtl/csadd_pkg.sv | 12 +
 rtl/csel_seg.sv | 29 ++
 rtl/csadd_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/csadd_pkg.sv
// csadd_pkg: shared constants and helpers
// for the pipelined carry-select adder.
package csadd_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nseg(input int w, input int s);
    return (s < 1) ? 0 : w / s;
  endfunction

endpackage

// File: rtl/csel_seg.sv
// csel_seg: one combinational carry-select
// segment; both carry cases, then select.
module csel_seg
  import csadd_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SEG_W:0] w_s0;
  logic [SEG_W:0] w_s1;

  assign w_s0 = {1'b0, a} + {1'b0, b};
  assign w_s1 = {1'b0, a} + {1'b0, b}
              + {{SEG_W{1'b0}}, 1'b1};

  assign {cout, sum} = cin ? w_s1 : w_s0;

  // carry into the MSB recovered from the sum bit
  assign cmsb = sum[SEG_W-1] ^ a[SEG_W-1]
              ^ b[SEG_W-1];

endmodule

// File: rtl/csadd_pipe.sv
// csadd_pipe: pipelined carry-select add/sub,
// one segment resolved per stage.
module csadd_pipe
  import csadd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (SEG_W < 1) begin : g_bad_seg
    $error("csadd_pipe: SEG_W must be >= 1");
  end else if ((WIDTH % SEG_W) != 0
               || NSEG < 1) begin : g_bad_w
    $error("csadd_pipe: bad WIDTH/SEG_W");
  end

  logic [NSEG-1:0]  w_v;
  logic [NSEG-1:0]  w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  assign w_b_eff   = (in_op == OP_SUB) ? ~in_b
                                       : in_b;
  assign w_cin_eff = (in_op == OP_SUB) ? 1'b1
                                       : in_cin;
  assign in_ready  = w_adv[0];

  // advance chain: a stage moves when empty or
  // when everything downstream moves
  always_comb begin
    w_adv = '0;
    w_adv[NSEG-1] = !w_v[NSEG-1] || out_ready;
    for (int i = NSEG - 2; i >= 0; i--) begin
      w_adv[i] = !w_v[i] || w_adv[i+1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int RW    = (NSEG - 1 - k) * SEG_W;
    localparam int SRC_W = RW + SEG_W;
    localparam int SW    = (k + 1) * SEG_W;

    logic [SRC_W-1:0] w_a_src;
    logic [SRC_W-1:0] w_b_src;
    logic [SEG_W-1:0] w_seg;
    logic [SW-1:0]    w_sum_nxt;
    logic             w_cin;
    logic             w_vin;
    logic             w_zin;
    logic             w_cout;
    logic             w_cm;
    logic             r_v;
    logic             r_c;
    logic             r_z;
    logic [SW-1:0]    r_sum;

    if (k == 0) begin : g_src
      assign w_a_src   = in_a;
      assign w_b_src   = w_b_eff;
      assign w_cin     = w_cin_eff;
      assign w_vin     = in_valid;
      assign w_zin     = 1'b1;
      assign w_sum_nxt = w_seg;
    end else begin : g_src
      assign w_a_src   = g_stg[k-1].g_rem.r_a;
      assign w_b_src   = g_stg[k-1].g_rem.r_b;
      assign w_cin     = g_stg[k-1].r_c;
      assign w_vin     = g_stg[k-1].r_v;
      assign w_zin     = g_stg[k-1].r_z;
      assign w_sum_nxt = {w_seg,
                          g_stg[k-1].r_sum};
    end

    csel_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a    (w_a_src[SEG_W-1:0]),
      .b    (w_b_src[SEG_W-1:0]),
      .cin  (w_cin),
      .sum  (w_seg),
      .cout (w_cout),
      .cmsb (w_cm)
    );

    assign w_v[k] = r_v;

    // stage valid, resolved low slices, carry
    // and running zero flag
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_z   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv[k]) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_sum <= w_sum_nxt;
          r_c   <= w_cout;
          r_z   <= w_zin && (w_seg == '0);
        end
      end
    end

    if (RW > 0) begin : g_rem
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;

      // carry the unprocessed upper slices along
      always_ff @(posedge clk) begin
        if (w_adv[k] && w_vin) begin
          r_a <= w_a_src[SRC_W-1:SEG_W];
          r_b <= w_b_src[SRC_W-1:SEG_W];
        end
      end
    end

    if (k == NSEG - 1) begin : g_last
      logic r_o;

      // signed overflow from carries at the MSB
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_o <= 1'b0;
        end else if (w_adv[k] && w_vin) begin
          r_o <= w_cm ^ w_cout;
        end
      end

      assign out_valid = r_v;
      assign out_sum   = r_sum;
      assign out_cout  = r_c;
      assign out_ovf   = r_o;
      assign out_zero  = r_z;
    end else begin : g_mid
      logic w_unused_cm;
      assign w_unused_cm = w_cm;
    end
  end

endmodule
